// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipe_pkg
// Brief    : Shared constants and helpers for the dff_pipe capture pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package dff_pipe_pkg;

    // One camera byte per pixel-bus word.
    localparam int DFF_PIPE_DEF_WIDTH = 8;
    localparam int DFF_PIPE_RESET_VAL = 0;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipe_stage
// Brief    : One pipeline slot: WIDTH-bit data register plus valid bit.
// Revision : 1.0 - initial release
// ============================================================================
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DFF_PIPE_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_flush) begin
            r_data  <= RESET_VAL;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipe
// Brief    : DEPTH-stage ready/valid register pipeline with inverted output.
//            Optional occupancy counter via DFF_PIPE_OCCUPANCY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DFF_PIPE_DEF_WIDTH,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_PIPE_RESET_VAL)
)(
    input  logic             pl,
    input  logic             Reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_data_bar
`ifdef DFF_PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_in_ready;

    // Walk from the output back: a stage may advance if it or any later stage is empty.
    always_comb begin : p_ready_chain
        logic w_acc;
        w_acc = out_ready;
        w_adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_acc    = w_acc || !w_valid[i];
            w_adv[i] = w_acc;
        end
    end

    assign w_in_ready = w_adv[0] && !flush;
    assign in_ready   = w_in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_d_in;
        logic             w_v_in;

        if (i == 0) begin : g_head
            assign w_d_in = in_data;
            assign w_v_in = in_valid && w_in_ready;
        end else begin : g_body
            assign w_d_in = w_data[i-1];
            assign w_v_in = w_valid[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (pl),
            .i_rst_n (Reset),
            .i_flush (flush),
            .i_load  (w_adv[i]),
            .i_data  (w_d_in),
            .i_valid (w_v_in),
            .o_data  (w_data[i]),
            .o_valid (w_valid[i])
        );
    end

    assign out_valid    = w_valid[DEPTH-1];
    assign out_data     = w_data[DEPTH-1];
    assign out_data_bar = ~w_data[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] r_occ;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = w_valid[DEPTH-1] && out_ready;

    // Simultaneous in and out transfers cancel, so the count stays within 0..DEPTH.
    always_ff @(posedge pl) begin
        if (!Reset || flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + 1'b1;
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign occupancy = r_occ;
`else
    // Occupancy counter compiled out; the data and flow-control paths are unaffected.
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_pipe
// Brief    : Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

    logic       pl = 1'b0;
    logic       Reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_data_bar;
`ifdef DFF_PIPE_OCCUPANCY_EN
    logic [1:0] occupancy;
`endif

    int total = 0;
    int bad   = 0;

    dff_pipe #(
        .WIDTH     (8),
        .DEPTH     (2),
        .RESET_VAL (8'h00)
    ) dut (
        .pl           (pl),
        .Reset        (Reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_data_bar (out_data_bar)
`ifdef DFF_PIPE_OCCUPANCY_EN
        ,
        .occupancy    (occupancy)
`endif
    );

    always #5 pl = ~pl;

    task automatic tick();
        @(posedge pl);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
        chk({tag, ".bar"},   {24'd0, out_data_bar}, {24'd0, ~d});
    endtask

    task automatic chk_occ(input string tag, input logic [1:0] exp);
`ifdef DFF_PIPE_OCCUPANCY_EN
        chk({tag, ".occ"}, {30'd0, occupancy}, {30'd0, exp});
`endif
    endtask

    initial begin
        // Reset held for two edges while a word is offered.
        Reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        tick();
        chk_out("rst1", 1'b0, 8'h00);
        tick();
        chk_out("rst2", 1'b0, 8'h00);
        chk_occ("rst2", 2'd0);
        Reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_rel.in_ready", {31'd0, in_ready}, 32'd1);

        // Unstalled stream 01..10: word k appears after edge k+1.
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            tick();
            chk("stream.in_ready", {31'd0, in_ready}, 32'd1);
            if (k == 1) chk_out("stream_first", 1'b0, out_data);
            else        chk_out("stream", 1'b1, 8'(k - 1));
        end
        in_valid = 1'b0;
        tick();
        chk_out("stream_last", 1'b1, 8'h10);
        tick();
        chk("stream_drain.valid", {31'd0, out_valid}, 32'd0);
        chk_occ("stream_drain", 2'd0);

        // Backpressure: fill with 11, 22 while stalled, 33 must wait.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        chk_out("bp_full", 1'b1, 8'h11);
        chk_occ("bp_full", 2'd2);
        in_data = 8'h33;
        #1;
        chk("bp_full.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk_out("bp_hold", 1'b1, 8'h11);
        chk("bp_hold.in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("bp_22", 1'b1, 8'h22);
        chk_occ("bp_22", 2'd2);
        in_valid = 1'b0;
        tick();
        chk_out("bp_33", 1'b1, 8'h33);
        tick();
        chk("bp_empty.valid", {31'd0, out_valid}, 32'd0);

        // Bubble in stage 0 with the output stalled is absorbed.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        chk_out("bubble_55", 1'b1, 8'h55);
        chk_occ("bubble_1", 2'd1);
        chk("bubble.in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h66;
        tick();
        chk_occ("bubble_2", 2'd2);
        chk_out("bubble_hold55", 1'b1, 8'h55);
        in_valid = 1'b0;
        tick();
        chk_occ("bubble_2hold", 2'd2);
        chk("bubble_full.in_ready", {31'd0, in_ready}, 32'd0);

        // Flush a full pipe while 44 is offered.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h44;
        #1;
        chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk_out("flush", 1'b0, 8'h00);
        chk_occ("flush", 2'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush_after1.valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("flush_after2.valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream, together with flush and an output transfer.
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_data = 8'h88;
        tick();
        chk_out("mid_77", 1'b1, 8'h77);
        Reset   = 1'b0;
        flush   = 1'b1;
        in_data = 8'h99;
        tick();
        chk_out("mid_rst", 1'b0, 8'h00);
        chk_occ("mid_rst", 2'd0);
        Reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rel.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("mid_after1.valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("mid_after2.valid", {31'd0, out_valid}, 32'd0);
        chk_occ("mid_after2", 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
